// File: rtl/mac_arbiter_if.sv
// Handshake and operand bundle between the operand sources, the
// mac_arbiter scheduler and the result consumer.
interface mac_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] a_in;
    logic [4*NREQ-1:0] b_in;
    logic [4*NREQ-1:0] c_in;
    logic [4*NREQ-1:0] d_in;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [7:0]        Q1;
    logic              ovf;

    // Requesters and result consumer side
    modport master (
        output req, a_in, b_in, c_in, d_in,
        input  gnt, busy, res_valid, res_id, Q1, ovf
    );

    // Scheduler side
    modport slave (
        input  req, a_in, b_in, c_in, d_in,
        output gnt, busy, res_valid, res_id, Q1, ovf
    );
endinterface

// File: rtl/mac_arbiter.sv
// Round-robin scheduler for a shared 4x4 multiplier computing
// Q1 = sat8(a*b + c*d). One operation takes two multiply cycles (a*b, then
// c*d) after a one-cycle grant; the result is tagged with the requester id.
module mac_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rstN,
    mac_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL1 = 2'd1,
        ST_MUL2 = 2'd2
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  last_id_r;
    logic [IDW-1:0]  win_id_r;
    logic [3:0]      a_r;
    logic [3:0]      b_r;
    logic [3:0]      c_r;
    logic [3:0]      d_r;
    logic [8:0]      acc_r;
    logic [NREQ-1:0] gnt_r;
    logic            busy_r;
    logic            res_valid_r;
    logic [IDW-1:0]  res_id_r;
    logic [7:0]      q1_r;
    logic            ovf_r;

    logic            sel_found_s;
    logic [IDW-1:0]  sel_id_s;
    logic [IDW-1:0]  idx_s;
    logic [3:0]      sel_a_s;
    logic [3:0]      sel_b_s;
    logic [3:0]      sel_c_s;
    logic [3:0]      sel_d_s;
    logic [3:0]      mul_x_s;
    logic [3:0]      mul_y_s;
    logic [7:0]      prod_s;
    logic [8:0]      sum_s;

    // Clamp a 9-bit sum to 8 bits; bit 8 set means the sum exceeded 255.
    function automatic logic [7:0] sat8(input logic [8:0] v);
        sat8 = v[8] ? 8'hFF : v[7:0];
    endfunction

    // Round-robin pick: first requester after last_id, ascending with wrap.
    always_comb begin
        sel_found_s = 1'b0;
        sel_id_s    = '0;
        idx_s       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s       = IDW'((int'(last_id_r) + k) % NREQ);
            sel_id_s    = (bus.req[idx_s] && !sel_found_s) ? idx_s : sel_id_s;
            sel_found_s = sel_found_s | bus.req[idx_s];
        end
    end

    // Route the winning requester's packed operands to the capture registers.
    always_comb begin
        sel_a_s = 4'd0;
        sel_b_s = 4'd0;
        sel_c_s = 4'd0;
        sel_d_s = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            sel_a_s = (sel_id_s == IDW'(i)) ? bus.a_in[4*i +: 4] : sel_a_s;
            sel_b_s = (sel_id_s == IDW'(i)) ? bus.b_in[4*i +: 4] : sel_b_s;
            sel_c_s = (sel_id_s == IDW'(i)) ? bus.c_in[4*i +: 4] : sel_c_s;
            sel_d_s = (sel_id_s == IDW'(i)) ? bus.d_in[4*i +: 4] : sel_d_s;
        end
    end

    // The one shared multiplier: c*d in MUL2, a*b otherwise; sum feeds MUL2.
    always_comb begin
        mul_x_s = a_r;
        mul_y_s = b_r;
        if (state_r == ST_MUL2) begin
            mul_x_s = c_r;
            mul_y_s = d_r;
        end else begin
            mul_x_s = a_r;
            mul_y_s = b_r;
        end
        prod_s = {4'd0, mul_x_s} * {4'd0, mul_y_s};
        sum_s  = acc_r + {1'b0, prod_s};
    end

    // Sequencer: grant and capture in IDLE, a*b in MUL1, finish in MUL2.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_r     <= ST_IDLE;
            last_id_r   <= IDW'(NREQ - 1);
            win_id_r    <= '0;
            a_r         <= 4'd0;
            b_r         <= 4'd0;
            c_r         <= 4'd0;
            d_r         <= 4'd0;
            acc_r       <= 9'd0;
            gnt_r       <= '0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_id_r    <= '0;
            q1_r        <= 8'd0;
            ovf_r       <= 1'b0;
        end else begin
            gnt_r       <= '0;
            res_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sel_found_s) begin
                        a_r       <= sel_a_s;
                        b_r       <= sel_b_s;
                        c_r       <= sel_c_s;
                        d_r       <= sel_d_s;
                        win_id_r  <= sel_id_s;
                        last_id_r <= sel_id_s;
                        gnt_r     <= {{(NREQ-1){1'b0}}, 1'b1} << sel_id_s;
                        busy_r    <= 1'b1;
                        state_r   <= ST_MUL1;
                    end else begin
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_MUL1: begin
                    acc_r   <= {1'b0, prod_s};
                    busy_r  <= 1'b1;
                    state_r <= ST_MUL2;
                end
                ST_MUL2: begin
                    q1_r        <= sat8(sum_s);
                    ovf_r       <= sum_s[8];
                    res_id_r    <= win_id_r;
                    res_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.busy      = busy_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_id    = res_id_r;
    assign bus.Q1        = q1_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_mac_arbiter.sv
// Scoreboard bench for mac_arbiter: a transaction-level model predicts grants
// and results from the requests it sees; a monitor compares DUT outputs.
module tb_mac_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct { int cyc; int id; } gnt_exp_t;
    typedef struct { int cyc; int id; int q; int ovf; } res_exp_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    mac_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    mac_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rstN(rstN), .bus(bus));

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    gnt_exp_t gq[$];
    res_exp_t rq[$];
    int  m_last     = NREQ - 1;
    int  m_cool     = 0;
    int  m_busy_k   = -10;
    bit  m_busy_act = 1'b0;
    int  held_q = 0, held_ovf = 0, held_id = 0;
    bit  granted_flag [NREQ];

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int opnd(input logic [4*NREQ-1:0] v, input int i);
        return int'(v[4*i +: 4]);
    endfunction

    // Reference model: an operation occupies the datapath for three cycles;
    // when free, the first requester after the last winner (with wrap) wins.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rstN) begin
            m_last = NREQ - 1; m_cool = 0; m_busy_act = 1'b0;
            gq.delete(); rq.delete();
            held_q = 0; held_ovf = 0; held_id = 0;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (bus.req != '0) begin
            int w, s;
            w = -1;
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && bus.req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            s = opnd(bus.a_in, w) * opnd(bus.b_in, w) + opnd(bus.c_in, w) * opnd(bus.d_in, w);
            gq.push_back('{cyc, w});
            rq.push_back('{cyc + 2, w, (s > 255) ? 255 : s, (s > 255) ? 1 : 0});
            m_last = w; m_cool = 2; m_busy_k = cyc; m_busy_act = 1'b1;
            granted_flag[w] = 1'b1;
        end
    end

    // Monitor: compare every cycle's outputs against the scoreboard.
    initial begin
        gnt_exp_t ge;
        res_exp_t re;
        bit busy_exp;
        forever begin
            @(negedge clk);
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                chk(1'b0, "gnt_missed", 0, gq[0].id);
                void'(gq.pop_front());
            end
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                ge = gq.pop_front();
                chk(bus.gnt === (NREQ'(1) << ge.id), "gnt_onehot", int'(bus.gnt), 1 << ge.id);
            end else begin
                chk(bus.gnt === '0, "gnt_idle", int'(bus.gnt), 0);
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk(1'b0, "res_missed", 0, rq[0].id);
                void'(rq.pop_front());
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                re = rq.pop_front();
                held_q = re.q; held_ovf = re.ovf; held_id = re.id;
                chk(bus.res_valid === 1'b1, "res_valid", int'(bus.res_valid), 1);
                chk(bus.res_id === IDW'(re.id), "res_id", int'(bus.res_id), re.id);
                chk(bus.Q1 === 8'(re.q), "q1", int'(bus.Q1), re.q);
                chk(bus.ovf === 1'(re.ovf), "ovf", int'(bus.ovf), re.ovf);
            end else begin
                chk(bus.res_valid === 1'b0, "res_spurious", int'(bus.res_valid), 0);
                chk(bus.Q1 === 8'(held_q) && bus.ovf === 1'(held_ovf) && bus.res_id === IDW'(held_id),
                    "hold_q1", int'(bus.Q1), held_q);
            end
            busy_exp = m_busy_act && (cyc == m_busy_k || cyc == m_busy_k + 1);
            chk(bus.busy === busy_exp, "busy", int'(bus.busy), int'(busy_exp));
        end
    end

    task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
        bus.a_in[4*i +: 4] = 4'(a);
        bus.b_in[4*i +: 4] = 4'(b);
        bus.c_in[4*i +: 4] = 4'(c);
        bus.d_in[4*i +: 4] = 4'(d);
    endtask

    task automatic request(input int i, input int a, input int b, input int c, input int d);
        set_ops(i, a, b, c, d);
        granted_flag[i] = 1'b0;
        bus.req[i] = 1'b1;
    endtask

    task automatic wait_grant(input int i, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (granted_flag[i]) begin seen = 1'b1; break; end
        end
        if (!seen) chk(1'b0, name, 0, 1);
    endtask

    task automatic wait_result(input int id, input int q, input int ov, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin seen = 1'b1; break; end
        end
        chk(seen, {name, "_seen"}, int'(seen), 1);
        if (seen) begin
            chk(bus.res_id === IDW'(id), {name, "_id"}, int'(bus.res_id), id);
            chk(bus.Q1 === 8'(q), {name, "_q1"}, int'(bus.Q1), q);
            chk(bus.ovf === 1'(ov), {name, "_ovf"}, int'(bus.ovf), ov);
        end
    endtask

    function automatic int rnd_op();
        return ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 15));
    endfunction

    // Directed scenarios followed by a randomized request phase.
    initial begin
        int gids[$];
        int gts[$];
        bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.c_in = '0; bus.d_in = '0;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        chk(bus.Q1 === 8'd0 && bus.busy === 1'b0 && bus.gnt === '0, "reset_state", int'(bus.Q1), 0);
        rstN = 1'b1;

        // single request
        request(0, 1, 2, 4, 2);
        wait_grant(0, "single_gnt_timeout");
        bus.req[0] = 1'b0;
        wait_result(0, 10, 0, "single");

        // saturation and the exact-255 boundary
        request(0, 15, 15, 15, 15);
        wait_grant(0, "sat_gnt_timeout");
        bus.req[0] = 1'b0;
        wait_result(0, 255, 1, "sat");
        request(0, 15, 15, 15, 2);
        wait_grant(0, "b255_gnt_timeout");
        bus.req[0] = 1'b0;
        wait_result(0, 255, 0, "b255");

        // operands changed after grant; another request raised while busy
        request(1, 3, 4, 5, 6);
        wait_grant(1, "mid_gnt_timeout");
        set_ops(1, 15, 15, 15, 15);
        bus.req[1] = 1'b0;
        request(2, 2, 2, 2, 2);
        wait_result(1, 42, 0, "latched");
        chk(granted_flag[2] == 1'b0, "req2_early", int'(granted_flag[2]), 0);
        wait_grant(2, "req2_gnt_timeout");
        bus.req[2] = 1'b0;
        wait_result(2, 8, 0, "req2");

        // reset while in MUL1
        request(0, 7, 7, 7, 7);
        wait_grant(0, "rst_gnt_timeout");
        rstN = 1'b0;
        bus.req = '0;
        @(negedge clk);
        chk(bus.Q1 === 8'd0 && bus.ovf === 1'b0 && bus.res_id === '0, "rst_outputs", int'(bus.Q1), 0);
        chk(bus.busy === 1'b0 && bus.gnt === '0 && bus.res_valid === 1'b0, "rst_ctrl", int'(bus.busy), 0);
        rstN = 1'b1;
        repeat (4) @(negedge clk);
        request(3, 5, 6, 7, 8);
        wait_grant(3, "after_rst_gnt_timeout");
        bus.req[3] = 1'b0;
        wait_result(3, 86, 0, "after_rst");

        // zero operands; the monitor checks Q1=86 is held until this result
        request(1, 0, 0, 0, 0);
        wait_grant(1, "zero_gnt_timeout");
        bus.req[1] = 1'b0;
        wait_result(1, 0, 0, "zero");

        // round-robin with all requests held from reset
        @(negedge clk);
        rstN = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 4*i + 3, 5, i + 1, 9);
        bus.req = '1;
        @(negedge clk);
        rstN = 1'b1;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (bus.gnt[i] === 1'b1) begin gids.push_back(i); gts.push_back(t); end
        end
        bus.req = '0;
        chk(gids.size() == 5, "rr_count", gids.size(), 5);
        for (int j = 0; j < 5; j++) begin
            if (j < gids.size()) begin
                chk(gids[j] == j % NREQ, "rr_order", gids[j], j % NREQ);
                if (j > 0) chk(gts[j] - gts[j-1] == 3, "rr_spacing", gts[j] - gts[j-1], 3);
            end
        end
        repeat (3) @(negedge clk);

        // randomized requesters
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req[i] !== 1'b1 || granted_flag[i]) begin
                    set_ops(i, rnd_op(), rnd_op(), rnd_op(), rnd_op());
                    granted_flag[i] = 1'b0;
                    bus.req[i] = ($urandom_range(0, 2) != 0);
                end
            end
        end
        bus.req = '0;
        repeat (8) @(negedge clk);
        chk(gq.size() == 0 && rq.size() == 0, "scoreboard_drain", gq.size() + rq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

Shared-datapath scheduler for the 4-bit multiply-accumulate unit that produces `Q1 = a*b + c*d`. It arbitrates NREQ requesters round-robin onto a single 4x4 multiplier and sequences each operation over two multiply cycles. It saturates the 9-bit sum to the 8-bit `Q1` result and returns the result tagged with the requester id. It sits between the operand sources and the result consumer, in place of per-requester MAC instances.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester id.

- `clk`  in  1  rising-edge clock.
- `rstN`  in  1  synchronous active-low reset.
- `req`  in  NREQ  per-requester request level.
- `a_in`, `b_in`, `c_in`, `d_in`  in  4*NREQ each  packed operands; requester i occupies bits [4i+3:4i].
- `gnt`  out  NREQ  one-hot grant pulse, one cycle long.
- `busy`  out  1  high while an operation is in flight.
- `res_valid`  out  1  one-cycle result strobe.
- `res_id`  out  IDW  requester that owns `Q1`.
- `Q1`  out  8  saturated result `a*b + c*d`.
- `ovf`  out  1  high when the true sum exceeded 255.

## Operation
- FSM has three states: IDLE, MUL1, MUL2.
  - **IDLE:** if any `req` is set, pick the winner, latch its four operands, register the one-hot `gnt` for the winner, update `last_id` to the winner, and go to MUL1. With no request, stay in IDLE.
  - **MUL1:** `acc[8:0] <= a*b` using the single shared multiplier; go to MUL2.
  - **MUL2:** `sum = acc + c*d` using the same multiplier.
    - Register `Q1 = (sum > 255) ? 255 : sum[7:0]`.
    - Register `ovf = (sum > 255)`.
    - Register `res_id` = winner and pulse `res_valid`; go to IDLE.
- Round-robin:
  - Search starts at `last_id+1` mod NREQ and ascends with wrap.
  - `last_id` resets to NREQ-1, so requester 0 has first priority after reset.
- `req` is sampled only in IDLE. Requests arriving during MUL1/MUL2 wait; nothing is queued beyond the level itself.
- A requester must hold `req` and its operands stable until its `gnt` is seen.
  - If `req` is still high in the IDLE cycle after completion, that is a new request, subject to round-robin.
- Operands are captured at grant. Changes on a granted requester's inputs after grant do not affect its result.
- `Q1`, `ovf` and `res_id` hold their last value until the next MUL2 completion.
- `busy` = (state != IDLE).
- Only one multiplier instance is permitted; the two products are never computed in the same cycle.

## Timing
- Reset (`rstN` low at a rising edge):
  - State goes to IDLE and `acc` to 0.
  - `gnt=0`, `busy=0`, `res_valid=0`, `res_id=0`, `Q1=0`, `ovf=0`, `last_id=NREQ-1`.
- Reset has priority over every transition. Reset during MUL1/MUL2 aborts the operation: no `res_valid`, no `gnt`, and the aborted requester is not remembered.
- Let E0 be the edge where IDLE samples a request:
  - E0: `gnt` and `busy` high for the following cycle.
  - E1: `gnt` low; state MUL2.
  - E2: `res_valid` high for one cycle, `Q1`/`ovf`/`res_id` updated, `busy` low.
- Latency from request-sampling edge to `res_valid` is 2 cycles.
- Under continuous requests, consecutive grants are 3 cycles apart and per-requester throughput is 1/(3*NREQ).
- `req` set in the same cycle as `res_valid` is sampled at the next edge; that cycle is IDLE.
- Arithmetic: the 4x4 product is 8 bits, max 225. `acc` is 9 bits; max sum is 450 and cannot wrap.
- Saturation threshold is strictly greater than 255: a sum of exactly 255 gives `ovf=0`.

## Test plan
- **Single request:** req[0] with a=1, b=2, c=4, d=2.
  - `gnt=0001` one cycle after the sampling edge.
  - `res_valid` 2 edges after sampling with `Q1=10`, `ovf=0`, `res_id=0`.
- **Saturation:** a=b=c=d=15 → `Q1=255`, `ovf=1`.
  - Boundary check: a=15, b=15, c=15, d=2 gives sum 255 → `Q1=255`, `ovf=0`.
- **Round-robin:** all four `req` held high from reset.
  - Grant order 0, 1, 2, 3, 0, grants 3 cycles apart.
  - Each `res_id` matches the preceding grant, and each `Q1` matches that requester's operands.
- **Mid-operation changes:**
  - Change the granted requester's operands in the cycle after `gnt` → result still reflects the latched values.
  - Assert req[2] while busy → it is granted only after `res_valid`.
- **Reset during MUL1:** all outputs 0 on the next edge, no `res_valid` pulse. A subsequent request from requester 3 alone is granted normally.
- **Zero operands:** req[1] with all operands 0 → `Q1=0`, `ovf=0`, `res_id=1`. Check that the previous `Q1` was held until this `res_valid`.
